ifu_stream_prefetcher: RTL and testbench

Multi-line sequential stream prefetcher for the IFU, successor to the single next-line prefetcher. It tracks a window of up to PF_MAX_DEPTH lines ahead of the CPU fetch line and issues their tags to memory over a valid/ready handshake. It records per-line PENDING/FILLED status from memory responses and slides the window on sequential advance or flushes it on a jump. It sits between the CPU fetch port, the instruction cache fill path and the memory request arbiter.

---
 rtl/ifu_pkg.sv | 10 +
 rtl/ifu_pf_window.sv | 47 ++++
 rtl/ifu_stream_prefetcher.sv | 73 +++++++
 tb/tb_ifu_stream_prefetcher.sv | 135 +++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// ifu_pkg: shared IFU types and default sizes for the stream prefetcher
package ifu_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int OFFSET_WIDTH = 4;
  localparam int TAG_WIDTH = ADDR_WIDTH - OFFSET_WIDTH;
  localparam int PF_MAX_DEPTH = 4;
  localparam int PF_MAX_OUTSTANDING = 2;
  typedef logic [TAG_WIDTH-1:0] t_pf_tag;
  typedef enum logic [1:0] {PF_EMPTY, PF_PENDING, PF_FILLED} t_pf_slot_state;
endpackage

// File: rtl/ifu_pf_window.sv
// ifu_pf_window: prefetch window base tag and per-line slot status
module ifu_pf_window
  import ifu_pkg::*;
#(
  parameter int TW = TAG_WIDTH,
  parameter int D = PF_MAX_DEPTH,
  parameter int IW = $clog2(D + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          shift,
  input  logic          flush,
  input  logic [TW-1:0] flush_tag,
  input  logic          fill,
  input  logic [TW-1:0] fill_tag,
  input  logic          mark,
  input  logic [IW-1:0] mark_idx,
  output logic [TW-1:0] base,
  output logic [D-1:0]  filled
);
  t_pf_slot_state slot [D];
  t_pf_slot_state eff [D];
  t_pf_slot_state slot_d [D];
  // fills match the pre-shift window; marks use the post-shift index
  always_comb begin
    for (int i = 0; i < D; i++) begin
      eff[i] = (fill && slot[i] == PF_PENDING && fill_tag == base + TW'(i + 1)) ? PF_FILLED : slot[i];
      slot_d[i] = eff[i];
      filled[i] = slot[i] == PF_FILLED;
    end
    if (shift) begin
      for (int i = 0; i < D - 1; i++) slot_d[i] = eff[i + 1];
      slot_d[D-1] = PF_EMPTY;
    end
    for (int i = 0; i < D; i++) if (mark && mark_idx == IW'(i)) slot_d[i] = PF_PENDING;
    if (flush) for (int i = 0; i < D; i++) slot_d[i] = PF_EMPTY;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      base <= '0;
      for (int i = 0; i < D; i++) slot[i] <= PF_EMPTY;
    end else begin
      base <= flush ? flush_tag : shift ? base + TW'(1) : base;
      slot <= slot_d;
    end
  end
endmodule

// File: rtl/ifu_stream_prefetcher.sv
// ifu_stream_prefetcher: multi-line sequential instruction prefetcher with memory handshake
module ifu_stream_prefetcher #(
  parameter int ADDR_WIDTH = ifu_pkg::ADDR_WIDTH,
  parameter int OFFSET_WIDTH = ifu_pkg::OFFSET_WIDTH,
  parameter int PF_MAX_DEPTH = ifu_pkg::PF_MAX_DEPTH,
  parameter int PF_MAX_OUTSTANDING = ifu_pkg::PF_MAX_OUTSTANDING,
  localparam int TAG_WIDTH = ADDR_WIDTH - OFFSET_WIDTH,
  localparam int DW = $clog2(PF_MAX_DEPTH + 1),
  localparam int OW = $clog2(PF_MAX_OUTSTANDING + 1)
) (
  input  logic                    Clock,
  input  logic                    Rst,
  input  logic                    pf_enableIn,
  input  logic [DW-1:0]           pf_depthIn,
  input  logic                    cpu_reqValidIn,
  input  logic [ADDR_WIDTH-1:0]   cpu_reqAddrIn,
  input  logic [TAG_WIDTH-1:0]    mem_rspTagIn,
  input  logic                    mem_rspInsLineValidIn,
  input  logic                    mem_reqReadyIn,
  output logic [TAG_WIDTH-1:0]    mem_reqTagOut,
  output logic                    mem_reqTagValidOut,
  output logic                    pf_hitOut,
  output logic [PF_MAX_DEPTH-1:0] pf_filledMaskOut,
  output logic                    pf_busyOut
);
  logic [TAG_WIDTH-1:0] base, cpu_tag;
  logic [DW-1:0] depth_q, nxt, nxt_s;
  logic [OW-1:0] oc;
  logic win_valid, same, seq, slide, jump, accept, mark, unused_ok;
  assign cpu_tag = cpu_reqAddrIn[ADDR_WIDTH-1:OFFSET_WIDTH];
  assign unused_ok = ^cpu_reqAddrIn[OFFSET_WIDTH-1:0];
  assign same = win_valid && cpu_tag == base;
  assign seq = win_valid && cpu_tag == base + TAG_WIDTH'(1);
  assign slide = cpu_reqValidIn && seq;
  assign jump = cpu_reqValidIn && !same && !seq;
  assign mem_reqTagValidOut = pf_enableIn && win_valid && nxt < depth_q && oc < OW'(PF_MAX_OUTSTANDING);
  assign mem_reqTagOut = mem_reqTagValidOut ? base + TAG_WIDTH'(nxt) + TAG_WIDTH'(1) : '0;
  assign accept = mem_reqTagValidOut && mem_reqReadyIn;
  assign nxt_s = (slide && nxt != '0) ? nxt - DW'(1) : nxt;
  // a request for slot0 accepted during a slide targets the line just consumed
  assign mark = accept && !jump && !(slide && nxt == '0);
  assign pf_hitOut = slide && pf_filledMaskOut[0];
  assign pf_busyOut = oc != '0;
  ifu_pf_window #(.TW(TAG_WIDTH), .D(PF_MAX_DEPTH), .IW(DW)) u_window (
    .clk(Clock),
    .rst(Rst),
    .shift(slide),
    .flush(jump),
    .flush_tag(cpu_tag),
    .fill(mem_rspInsLineValidIn),
    .fill_tag(mem_rspTagIn),
    .mark(mark),
    .mark_idx(nxt_s),
    .base(base),
    .filled(pf_filledMaskOut)
  );
  always_ff @(posedge Clock) begin
    if (Rst) begin
      win_valid <= 1'b0;
      depth_q <= '0;
      nxt <= '0;
      oc <= '0;
    end else begin
      if (jump) begin
        win_valid <= 1'b1;
        depth_q <= pf_depthIn > DW'(PF_MAX_DEPTH) ? DW'(PF_MAX_DEPTH) : pf_depthIn;
      end
      nxt <= jump ? '0 : nxt_s + DW'(mark);
      oc <= (accept && !mem_rspInsLineValidIn) ? oc + OW'(1) :
            (!accept && mem_rspInsLineValidIn && oc != '0) ? oc - OW'(1) : oc;
    end
  end
endmodule

// File: tb/tb_ifu_stream_prefetcher.sv
// tb_ifu_stream_prefetcher: directed and random checks against a tag-keyed window model
module tb_ifu_stream_prefetcher;
  localparam int TW = 28;
  localparam int D = 4;
  localparam int MO = 2;
  logic clk = 1'b0, rst, enable, cpu_valid, rsp_valid, ready;
  logic [2:0] depth;
  logic [31:0] cpu_addr;
  logic [TW-1:0] rsp_tag, req_tag;
  logic req_valid, hit, busy;
  logic [D-1:0] mask;
  int n_assert = 0, n_fail = 0;
  logic [TW-1:0] mb;
  logic mwv;
  int mdepth, moc;
  int ms [D];
  logic o_valid, o_hit, o_busy;
  logic [TW-1:0] o_tag;
  logic [D-1:0] o_mask;

  always #5 clk = ~clk;

  ifu_stream_prefetcher dut (
    .Clock(clk), .Rst(rst), .pf_enableIn(enable), .pf_depthIn(depth),
    .cpu_reqValidIn(cpu_valid), .cpu_reqAddrIn(cpu_addr), .mem_rspTagIn(rsp_tag),
    .mem_rspInsLineValidIn(rsp_valid), .mem_reqReadyIn(ready), .mem_reqTagOut(req_tag),
    .mem_reqTagValidOut(req_valid), .pf_hitOut(hit), .pf_filledMaskOut(mask), .pf_busyOut(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mb = '0; mwv = 1'b0; mdepth = 0; moc = 0;
    for (int i = 0; i < D; i++) ms[i] = 0;
  endtask

  // slot codes: 0 empty, 1 pending, 2 filled; slot i holds line mb+1+i
  task automatic step(input logic r, input logic cv, input logic [31:0] a, input logic en,
                      input int din, input logic rdy, input logic rv, input logic [TW-1:0] rt);
    int nx, idx;
    logic ev, eh, acc, jmp;
    logic [TW-1:0] t, rq;
    logic [D-1:0] em;
    rst = r; cpu_valid = cv; cpu_addr = a; enable = en; depth = 3'(din);
    ready = rdy; rsp_valid = rv; rsp_tag = rt;
    #1;
    nx = 0; em = '0;
    for (int i = 0; i < D; i++) begin
      if (ms[i] != 0) nx++;
      em[i] = ms[i] == 2;
    end
    t = a[31:4];
    ev = en && mwv && nx < mdepth && moc < MO;
    rq = TW'(mb + TW'(nx + 1));
    eh = cv && mwv && t == TW'(mb + 1) && ms[0] == 2;
    o_valid = req_valid; o_tag = req_tag; o_hit = hit; o_mask = mask; o_busy = busy;
    chk("req_valid", o_valid, ev);
    chk("req_tag", o_tag, ev ? rq : '0);
    chk("hit", o_hit, eh);
    chk("filled_mask", o_mask, em);
    chk("busy", o_busy, moc != 0);
    if (r) model_reset();
    else begin
      acc = ev && rdy;
      jmp = 1'b0;
      if (rv) for (int i = 0; i < D; i++) if (ms[i] == 1 && rt == TW'(mb + TW'(i + 1))) ms[i] = 2;
      if (cv && mwv && t == mb) ;
      else if (cv && mwv && t == TW'(mb + 1)) begin
        for (int i = 0; i < D - 1; i++) ms[i] = ms[i+1];
        ms[D-1] = 0; mb = t;
      end else if (cv) begin
        jmp = 1'b1; mb = t; mwv = 1'b1; mdepth = din > D ? D : din;
        for (int i = 0; i < D; i++) ms[i] = 0;
      end
      idx = int'(TW'(rq - mb - 1));
      if (acc && !jmp && idx < D) ms[idx] = 1;
      if (acc && !rv) moc++;
      else if (rv && !acc && moc > 0) moc--;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [TW-1:0] ct, rtg;
    int sel;
    rst = 1'b1; enable = 0; depth = 0; cpu_valid = 0; cpu_addr = 0;
    rsp_valid = 0; rsp_tag = 0; ready = 0;
    @(negedge clk);
    model_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_mask", o_mask, 0);
    step(0, 1, 32'h100, 1, 4, 1, 0, 0);
    step(0, 0, 0, 1, 4, 1, 0, 0); chk("first_tag", o_tag, 'h11);
    step(0, 0, 0, 1, 4, 1, 0, 0); chk("second_tag", o_tag, 'h12);
    step(0, 0, 0, 1, 4, 1, 0, 0); chk("stall_full", o_valid, 0);
    step(0, 0, 0, 1, 4, 1, 1, 'h11); chk("mask_before_rsp", o_mask, 0);
    step(0, 0, 0, 1, 4, 0, 1, 'h12);
    step(0, 1, 32'h110, 1, 4, 0, 0, 0); chk("seq_hit", o_hit, 1);
    step(0, 0, 0, 1, 4, 1, 0, 0); chk("slide_mask", o_mask, 'b0001); chk("slide_tag", o_tag, 'h13);
    step(0, 0, 0, 1, 4, 1, 0, 0);
    step(0, 1, 32'h800, 1, 4, 1, 0, 0);
    step(0, 0, 0, 1, 4, 1, 1, 'h13); chk("late_rsp_mask", o_mask, 0);
    step(0, 0, 0, 1, 4, 1, 1, 'h14); chk("jump_tag", o_tag, 'h81);
    step(0, 0, 0, 1, 4, 1, 1, 'h82); chk("issue_rsp_tag", o_tag, 'h82); chk("oc_held", o_busy, 1);
    step(0, 0, 0, 1, 4, 0, 0, 0); chk("pending_not_filled", o_mask, 0);
    for (int k = 0; k < 10; k++) begin
      step(0, 0, 0, 0, 4, 1, 0, 0); chk("disabled_valid", o_valid, 0);
    end
    step(0, 0, 0, 1, 4, 1, 0, 0); chk("resume_tag", o_tag, 'h83);
    step(0, 0, 0, 1, 4, 0, 1, 'h81);
    step(0, 0, 0, 1, 4, 0, 1, 'h82);
    step(0, 0, 0, 1, 4, 0, 0, 0); chk("drained_mask", o_mask, 'b0011); chk("drained_busy", o_busy, 0);
    step(0, 1, 32'hFFFF_FFF0, 1, 2, 0, 0, 0);
    step(0, 0, 0, 1, 2, 1, 0, 0); chk("wrap_tag0", o_tag, 'h0);
    step(0, 0, 0, 1, 2, 1, 0, 0); chk("wrap_tag1", o_tag, 'h1);
    step(0, 0, 0, 1, 2, 1, 0, 0); chk("depth_cap", o_valid, 0);
    step(0, 0, 0, 1, 2, 0, 1, 'h0);
    step(0, 1, 32'h0000_0000, 1, 2, 0, 0, 0); chk("wrap_hit", o_hit, 1);
    for (int k = 0; k < 400; k++) begin
      sel = int'($urandom_range(0, 15));
      ct = sel < 7 ? mb : sel < 13 ? TW'(mb + 1) : sel == 13 ? '1 : TW'($urandom);
      rtg = TW'(mb + TW'($urandom_range(0, 5)));
      step(k == 200, $urandom_range(0, 2) != 0, {ct, 4'($urandom)}, $urandom_range(0, 7) != 0,
           int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, rtg);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
